// File: rtl/md_issue_tracker_pkg.sv
// md_issue_tracker_pkg: opcode/funct constants and tracker state encoding shared by the MD issue tracker.
package md_issue_tracker_pkg;
    localparam logic [5:0] OP_CAL_MD = 6'b000000;
    localparam logic [5:0] F_MULT    = 6'b011000;
    localparam logic [5:0] F_MULTU   = 6'b011001;
    localparam logic [5:0] F_DIV     = 6'b011010;
    localparam logic [5:0] F_DIVU    = 6'b011011;
    localparam logic [5:0] F_MFHI    = 6'b010000;
    localparam logic [5:0] F_MTHI    = 6'b010001;
    localparam logic [5:0] F_MFLO    = 6'b010010;
    localparam logic [5:0] F_MTLO    = 6'b010011;
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2
    } md_state_e;
endpackage

// File: rtl/md_issue_tracker_if.sv
// md_issue_tracker_if: pipeline-side signals of the MD issue tracker; master drives D/E words and flags.
interface md_issue_tracker_if;
    logic [31:0] instr_D;
    logic [31:0] instr_E;
    logic        Req;
    logic        Busy;
    logic        stall_md;
    logic        md_busy_track;
    logic [3:0]  md_cnt;
    logic        md_err;
    modport master (output instr_D, instr_E, Req, Busy, input stall_md, md_busy_track, md_cnt, md_err);
    modport slave  (input instr_D, instr_E, Req, Busy, output stall_md, md_busy_track, md_cnt, md_err);
endinterface

// File: rtl/md_issue_tracker_md_class_dec.sv
// md_class_dec: classifies an instruction word as MD-class, start-class (mult/div family) and divide.
module md_class_dec
    import md_issue_tracker_pkg::*;
(
    input  logic [31:0] instr,
    output logic        is_md,
    output logic        is_start,
    output logic        is_div
);
    logic r_type;
    assign r_type   = instr[31:26] == OP_CAL_MD;
    // funct 0110xx is mult/multu/div/divu, 0100xx is mfhi/mthi/mflo/mtlo
    assign is_start = r_type && instr[5:2] == F_MULT[5:2];
    assign is_div   = is_start && instr[1];
    assign is_md    = is_start || (r_type && instr[5:2] == F_MFHI[5:2]);
endmodule

// File: rtl/md_issue_tracker.sv
// md_issue_tracker: shadows the HI/LO unit's busy window and stalls D on MD-class hazards.
// Optional busy cross-check against the unit's Busy flag is enabled by MD_BUSY_CHECK_EN.
module md_issue_tracker
    import md_issue_tracker_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic               clk,
    input logic               reset,
    md_issue_tracker_if.slave bus
);
    md_state_e  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       d_md, d_start, d_div;
    logic       e_md, e_start, e_div;
    logic       idle, start;

    md_class_dec u_dec_d (.instr(bus.instr_D), .is_md(d_md), .is_start(d_start), .is_div(d_div));
    md_class_dec u_dec_e (.instr(bus.instr_E), .is_md(e_md), .is_start(e_start), .is_div(e_div));

    assign idle  = state_q == MD_IDLE;
    assign start = e_start && !bus.Req;

    // a start while busy is ignored, matching the MD unit
    always_comb begin
        state_d = idle ? (start ? (e_div ? MD_DIV : MD_MUL) : MD_IDLE) : (cnt_q <= 4'd1 ? MD_IDLE : state_q);
        cnt_d   = idle ? (start ? (e_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES)) : 4'd0) : cnt_q - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.stall_md      = d_md && (start || !idle);
    assign bus.md_busy_track = !idle;
    assign bus.md_cnt        = cnt_q;

`ifdef MD_BUSY_CHECK_EN
    logic err_q;
    always_ff @(posedge clk) begin
        if (reset)
            err_q <= 1'b0;
        else if (bus.md_busy_track != bus.Busy)
            err_q <= 1'b1;
    end
    assign bus.md_err = err_q;
`else
    assign bus.md_err = 1'b0;
`endif
endmodule

// File: tb/tb_md_issue_tracker.sv
// tb_md_issue_tracker: directed-vector bench for md_issue_tracker; Busy mimics the MD unit each cycle.
module tb_md_issue_tracker;
    localparam logic [31:0] NOP   = 32'h0000_0000;
    localparam logic [31:0] ADD   = 32'h0022_1820;
    localparam logic [31:0] MULT  = 32'h0022_0018;
    localparam logic [31:0] DIV   = 32'h0022_001a;
    localparam logic [31:0] DIVU  = 32'h0022_001b;
    localparam logic [31:0] MFHI  = 32'h0000_1810;
    localparam logic [31:0] MFLO  = 32'h0000_1812;
    localparam logic [31:0] MTHI  = 32'h0020_0011;
`ifdef MD_BUSY_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    md_issue_tracker_if bus ();
    md_issue_tracker dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.instr_D = ADD;
        bus.instr_E = NOP;
        bus.Req = 1'b0;
        bus.Busy = 1'b0;
        step();
        step();
        #1;
        vectors++;
        if (bus.md_cnt !== 4'd0) begin miscompares++; $display("FAIL reset_cnt got %0d want 0", bus.md_cnt); end
        vectors++;
        if (bus.md_busy_track !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", bus.md_busy_track); end
        vectors++;
        if (bus.md_err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", bus.md_err); end
        vectors++;
        if (bus.stall_md !== 1'b0) begin miscompares++; $display("FAIL reset_stall got %b want 0", bus.stall_md); end
        reset = 1'b0;
    endtask

    task automatic test_idle_traffic();
        bus.instr_D = ADD;
        bus.instr_E = ADD;
        for (int i = 0; i < 20; i++) begin
            step();
            #1;
            vectors++;
            if (bus.stall_md !== 1'b0 || bus.md_cnt !== 4'd0 || bus.md_busy_track !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_c%0d got stall=%b cnt=%0d busy=%b want 0/0/0", i, bus.stall_md, bus.md_cnt, bus.md_busy_track);
            end
        end
    endtask

    task automatic test_mult_back_to_back();
        int stalls;
        bus.instr_D = MFHI;
        bus.instr_E = MULT;
        bus.Busy = 1'b0;
        #1;
        vectors++;
        if (bus.stall_md !== 1'b1) begin miscompares++; $display("FAIL mult_eterm_stall got %b want 1", bus.stall_md); end
        stalls = int'(bus.stall_md);
        for (int i = 5; i >= 0; i--) begin
            step();
            bus.instr_E = NOP;
            bus.Busy = (i != 0);
            #1;
            vectors++;
            if (bus.md_cnt !== 4'(i)) begin miscompares++; $display("FAIL mult_cnt got %0d want %0d", bus.md_cnt, i); end
            vectors++;
            if (bus.md_busy_track !== (i != 0)) begin miscompares++; $display("FAIL mult_busy@%0d got %b want %b", i, bus.md_busy_track, i != 0); end
            vectors++;
            if (bus.stall_md !== (i != 0)) begin miscompares++; $display("FAIL mult_stall@%0d got %b want %b", i, bus.stall_md, i != 0); end
            stalls += int'(bus.stall_md);
        end
        vectors++;
        if (stalls != 6) begin miscompares++; $display("FAIL mult_stall_total got %0d want 6", stalls); end
        bus.instr_D = ADD;
    endtask

    task automatic test_req_cancel();
        bus.instr_D = MFLO;
        bus.instr_E = DIVU;
        bus.Req = 1'b1;
        #1;
        vectors++;
        if (bus.stall_md !== 1'b0) begin miscompares++; $display("FAIL req_stall got %b want 0", bus.stall_md); end
        step();
        bus.Req = 1'b0;
        bus.instr_E = MTHI;
        bus.instr_D = MFHI;
        #1;
        vectors++;
        if (bus.md_cnt !== 4'd0 || bus.md_busy_track !== 1'b0) begin
            miscompares++;
            $display("FAIL req_state got cnt=%0d busy=%b want 0/0", bus.md_cnt, bus.md_busy_track);
        end
        vectors++;
        if (bus.stall_md !== 1'b0) begin miscompares++; $display("FAIL mthi_stall got %b want 0", bus.stall_md); end
        step();
        bus.instr_E = NOP;
        #1;
        vectors++;
        if (bus.md_cnt !== 4'd0) begin miscompares++; $display("FAIL mthi_cnt got %0d want 0", bus.md_cnt); end
        bus.instr_D = ADD;
    endtask

    task automatic test_reset_in_div();
        bus.instr_D = MFLO;
        bus.instr_E = DIV;
        step();
        bus.instr_E = NOP;
        bus.Busy = 1'b1;
        for (int i = 0; i < 4; i++) step();
        #1;
        vectors++;
        if (bus.md_cnt !== 4'd6) begin miscompares++; $display("FAIL div_cnt6 got %0d want 6", bus.md_cnt); end
        reset = 1'b1;
        step();
        bus.Busy = 1'b0;
        #1;
        vectors++;
        if (bus.md_cnt !== 4'd0 || bus.md_busy_track !== 1'b0 || bus.stall_md !== 1'b0) begin
            miscompares++;
            $display("FAIL div_reset got cnt=%0d busy=%b stall=%b want 0/0/0", bus.md_cnt, bus.md_busy_track, bus.stall_md);
        end
        bus.instr_D = ADD;
        bus.instr_E = MULT;
        step();
        #1;
        vectors++;
        if (bus.md_cnt !== 4'd0 || bus.md_busy_track !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_vs_start got cnt=%0d busy=%b want 0/0", bus.md_cnt, bus.md_busy_track);
        end
        bus.instr_E = NOP;
        reset = 1'b0;
    endtask

    task automatic test_start_while_busy();
        bus.instr_E = DIV;
        step();
        bus.instr_E = NOP;
        bus.Busy = 1'b1;
        for (int i = 0; i < 6; i++) step();
        #1;
        vectors++;
        if (bus.md_cnt !== 4'd4) begin miscompares++; $display("FAIL div_cnt4 got %0d want 4", bus.md_cnt); end
        bus.instr_E = MULT;
        for (int i = 3; i >= 0; i--) begin
            step();
            bus.Busy = (i != 0);
            if (i == 0) bus.instr_E = NOP;
            #1;
            vectors++;
            if (bus.md_cnt !== 4'(i)) begin miscompares++; $display("FAIL ignore_start_cnt got %0d want %0d", bus.md_cnt, i); end
        end
        step();
        #1;
        vectors++;
        if (bus.md_busy_track !== 1'b0) begin miscompares++; $display("FAIL ignore_start_idle got %b want 0", bus.md_busy_track); end
    endtask

    task automatic test_busy_check();
        bus.instr_E = MULT;
        bus.Busy = 1'b0;
        step();
        bus.instr_E = NOP;
        for (int i = 5; i >= 1; i--) begin
            bus.Busy = (i != 1);
            #1;
            vectors++;
            if (bus.md_err !== 1'b0) begin miscompares++; $display("FAIL chk_err_early@%0d got %b want 0", i, bus.md_err); end
            step();
        end
        bus.Busy = 1'b0;
        #1;
        vectors++;
        if (bus.md_err !== EXP_ERR) begin miscompares++; $display("FAIL chk_err_rise got %b want %b", bus.md_err, EXP_ERR); end
        step();
        step();
        vectors++;
        if (bus.md_err !== EXP_ERR) begin miscompares++; $display("FAIL chk_err_sticky got %b want %b", bus.md_err, EXP_ERR); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        vectors++;
        if (bus.md_err !== 1'b0) begin miscompares++; $display("FAIL chk_err_clear got %b want 0", bus.md_err); end
    endtask

    initial begin
        test_reset();
        test_idle_traffic();
        test_mult_back_to_back();
        test_req_cancel();
        test_reset_in_div();
        test_start_while_busy();
        test_busy_check();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
